// File: rtl/gray_input_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared types and helpers for the Gray-code switch debouncer.
//   deb_state_t             : debouncer FSM state encoding
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms at 27 MHz
//   GRAY_MAX_WIDTH          : widest word gray2bin handles
//   gray2bin()              : Gray to binary conversion on a zero-extended word
// ---------------------------------------------------------------------------
package gray_pkg;

    typedef enum logic [1:0] {
        S_STABLE = 2'd0,
        S_COUNT  = 2'd1,
        S_COMMIT = 2'd2
    } deb_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 270000;
    localparam int GRAY_MAX_WIDTH          = 32;

    // b[i] is the XOR of g[i] and every bit above it. Callers zero-extend
    // narrower words, so the zero upper bits do not disturb the result and
    // the lower WIDTH bits of the return value are the binary equivalent.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
        input logic [GRAY_MAX_WIDTH-1:0] g
    );
        logic [GRAY_MAX_WIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < GRAY_MAX_WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_input_debouncer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for an asynchronous multi-bit input.
// Each bit is synchronised independently. This is safe for the debouncer
// because any skew between bits only appears as a short-lived code, and the
// debounce window rejects it.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages to 0
//   d   : asynchronous input word
//   q   : synchronised output word, two clk edges after d
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gray_input_debouncer.sv
// ---------------------------------------------------------------------------
// gray_input_debouncer
// Samples a Gray code from board switches, synchronises and debounces it,
// then converts it to binary for the LED driver.
// Optional feature macro: GRAY_STEP_CHECK_EN. When it is defined, step_err
// flags any committed code that differs from the previous code by other than
// exactly one bit. When it is undefined, step_err is tied to 0.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   gray_in  : raw Gray code from the switches (asynchronous, may bounce)
//   binary   : registered binary value of the last accepted code
//   valid    : one-cycle pulse in the cycle binary takes a new value
//   step_err : last accepted code was not a single-bit step
//
// State table
//   state    | meaning
//   S_STABLE | g_s matches the committed code; waiting for a change
//   S_COUNT  | counting consecutive cycles with g_s equal to cand
//   S_COMMIT | valid cycle: binary/stable_gray were loaded on entry
// ---------------------------------------------------------------------------
module gray_input_debouncer
    import gray_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] binary,
    output logic             valid,
    output logic             step_err
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    deb_state_t       state, state_next;
    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] stable_gray;
    logic [WIDTH-1:0] cand, cand_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             commit;
    logic [WIDTH-1:0] cand_bin;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gray_in),
        .q   (g_s)
    );

    assign cand_bin = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(cand)));

    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            S_STABLE: begin
                if (g_s != stable_gray) begin
                    cand_next  = g_s;
                    cnt_next   = '0;
                    state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (g_s == cand) begin
                    cnt_next = cnt + CNT_W'(1);
                    // The commit is registered on the last counting edge.
                    // The S_COMMIT state is the cycle in which valid is high.
                    if (cnt == CNT_TC) begin
                        commit     = 1'b1;
                        state_next = S_COMMIT;
                    end
                end else if (g_s == stable_gray) begin
                    state_next = S_STABLE;
                end else begin
                    cand_next = g_s;
                    cnt_next  = '0;
                end
            end
            S_COMMIT: begin
                // A change that arrives here is picked up next cycle in
                // S_STABLE, because stable_gray is already updated.
                state_next = S_STABLE;
            end
            default: begin
                state_next = S_STABLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_STABLE;
            cand        <= '0;
            cnt         <= '0;
            stable_gray <= '0;
            binary      <= '0;
            valid       <= 1'b0;
        end else begin
            state <= state_next;
            cand  <= cand_next;
            cnt   <= cnt_next;
            valid <= commit;
            if (commit) begin
                stable_gray <= cand;
                binary      <= cand_bin;
            end
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_err <= 1'b0;
        end else if (commit) begin
            step_err <= ($countones(cand ^ stable_gray) != 1);
        end
    end
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_input_debouncer.sv
module tb_gray_input_debouncer;

    localparam int WIDTH = 4;
    localparam int DEB   = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] gray_in;
    logic [WIDTH-1:0] binary;
    logic             valid;
    logic             step_err;

    int tests;
    int fails;

    gray_input_debouncer #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gray_in  (gray_in),
        .binary   (binary),
        .valid    (valid),
        .step_err (step_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        gray_in = 4'b0110;
        repeat (3) tick();
        tests++;
        if (binary !== 4'b0000) begin
            fails++;
            $display("FAIL reset_binary: got %b required 0000", binary);
        end
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b required 0", valid);
        end
        tests++;
        if (step_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_step_err: got %b required 0", step_err);
        end
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            tests++;
            if (valid !== 1'b0) begin
                fails++;
                $display("FAIL latency_early_valid edge %0d: got %b required 0", i, valid);
            end
        end
        tick();
        tests++;
        if (valid !== 1'b1) begin
            fails++;
            $display("FAIL latency_valid edge 7: got %b required 1", valid);
        end
        tests++;
        if (binary !== 4'b0100) begin
            fails++;
            $display("FAIL latency_binary: got %b required 0100", binary);
        end
        tick();
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL valid_one_cycle: got %b required 0", valid);
        end
    endtask

    task automatic test_sweep();
        int n;
        logic [3:0] g;
        logic [3:0] v4;
        // Park at Gray(15) so the first sweep code is a one-bit step.
        gray_in = 4'b1000;
        repeat (10) tick();
        tests++;
        if (binary !== 4'b1111) begin
            fails++;
            $display("FAIL sweep_preset: got %b required 1111", binary);
        end
        n = 0;
        for (int v = 0; v < 16; v++) begin
            v4 = 4'(v);
            g  = v4 ^ (v4 >> 1);
            gray_in = g;
            repeat (10) begin
                tick();
                if (valid === 1'b1) begin
                    tests++;
                    if (binary !== 4'(n)) begin
                        fails++;
                        $display("FAIL sweep_order pulse %0d: got %b required %b", n, binary, 4'(n));
                    end
                    tests++;
                    if (step_err !== 1'b0) begin
                        fails++;
                        $display("FAIL sweep_step_err pulse %0d: got %b required 0", n, step_err);
                    end
                    n++;
                end
            end
        end
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL sweep_pulse_count: got %0d required 16", n);
        end
        tests++;
        if (binary !== 4'b1111) begin
            fails++;
            $display("FAIL sweep_final: got %b required 1111", binary);
        end
    endtask

    task automatic test_bounce();
        int n;
        gray_in = 4'b0000;
        repeat (10) tick();
        tests++;
        if (binary !== 4'b0000) begin
            fails++;
            $display("FAIL bounce_preset: got %b required 0000", binary);
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            gray_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            repeat (2) begin
                tick();
                if (valid === 1'b1) n++;
            end
        end
        gray_in = 4'b0001;
        repeat (12) begin
            tick();
            if (valid === 1'b1) n++;
        end
        tests++;
        if (n != 1) begin
            fails++;
            $display("FAIL bounce_pulse_count: got %0d required 1", n);
        end
        tests++;
        if (binary !== 4'b0001) begin
            fails++;
            $display("FAIL bounce_binary: got %b required 0001", binary);
        end
    endtask

    task automatic test_glitch_abort();
        int n;
        gray_in = 4'b0000;
        repeat (10) tick();
        tests++;
        if (binary !== 4'b0000) begin
            fails++;
            $display("FAIL glitch_preset: got %b required 0000", binary);
        end
        n = 0;
        gray_in = 4'b0011;
        repeat (3) begin
            tick();
            if (valid === 1'b1) n++;
        end
        gray_in = 4'b0000;
        repeat (12) begin
            tick();
            if (valid === 1'b1) n++;
        end
        tests++;
        if (n != 0) begin
            fails++;
            $display("FAIL glitch_pulse_count: got %0d required 0", n);
        end
        tests++;
        if (binary !== 4'b0000) begin
            fails++;
            $display("FAIL glitch_binary: got %b required 0000", binary);
        end
    endtask

    task automatic test_step_check();
        int n;
        logic exp_err;
`ifdef GRAY_STEP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        n = 0;
        gray_in = 4'b0011;
        repeat (10) begin
            tick();
            if (valid === 1'b1) n++;
        end
        tests++;
        if (n != 1) begin
            fails++;
            $display("FAIL step1_pulse_count: got %0d required 1", n);
        end
        tests++;
        if (binary !== 4'b0010) begin
            fails++;
            $display("FAIL step1_binary: got %b required 0010", binary);
        end
        tests++;
        if (step_err !== exp_err) begin
            fails++;
            $display("FAIL step1_step_err: got %b required %b", step_err, exp_err);
        end
        n = 0;
        gray_in = 4'b0010;
        repeat (10) begin
            tick();
            if (valid === 1'b1) n++;
        end
        tests++;
        if (n != 1) begin
            fails++;
            $display("FAIL step2_pulse_count: got %0d required 1", n);
        end
        tests++;
        if (binary !== 4'b0011) begin
            fails++;
            $display("FAIL step2_binary: got %b required 0011", binary);
        end
        tests++;
        if (step_err !== 1'b0) begin
            fails++;
            $display("FAIL step2_step_err: got %b required 0", step_err);
        end
    endtask

    task automatic test_reset_midcount();
        int n;
        gray_in = 4'b0110;
        // 2 sync edges, 1 detect edge, then 2 counting edges.
        repeat (5) tick();
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if (binary !== 4'b0000) begin
            fails++;
            $display("FAIL midreset_binary: got %b required 0000", binary);
        end
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_valid: got %b required 0", valid);
        end
        tests++;
        if (step_err !== 1'b0) begin
            fails++;
            $display("FAIL midreset_step_err: got %b required 0", step_err);
        end
        gray_in = 4'b0000;
        repeat (2) tick();
        rst = 1'b0;
        n = 0;
        repeat (12) begin
            tick();
            if (valid === 1'b1) n++;
        end
        tests++;
        if (n != 0) begin
            fails++;
            $display("FAIL midreset_pulse_count: got %0d required 0", n);
        end
        tests++;
        if (binary !== 4'b0000) begin
            fails++;
            $display("FAIL midreset_binary_after: got %b required 0000", binary);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        gray_in = '0;
        test_reset();
        test_sweep();
        test_bounce();
        test_glitch_abort();
        test_step_check();
        test_reset_midcount();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
